// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter that shares one AHB-Lite master port between NUM_REQ
// requesters, one single 32-bit transfer at a time, with a data-phase watchdog.
module ahb_master_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [32*NUM_REQ-1:0] req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic [31:0]           rdata,
    output logic                  resp,
    output logic [1:0]            m_trans,
    output logic                  m_write,
    output logic [31:0]           m_addr,
    output logic [31:0]           m_wdata,
    input  logic [31:0]           m_rdata,
    input  logic                  m_resp,
    input  logic                  m_ready
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     wait_q, wait_d;
    logic [1:0]           m_trans_q, m_trans_d;
    logic                 m_write_q, m_write_d;
    logic [31:0]          m_addr_q, m_addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          m_wdata_q, m_wdata_d;

    logic [NUM_REQ-1:0][31:0] addr_arr;
    logic [NUM_REQ-1:0][31:0] wdata_arr;
    logic [NUM_REQ-1:0]   req_m;
    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic [NUM_REQ-1:0]   win_onehot;
    logic                 win_write;
    logic [31:0]          win_addr;
    logic [31:0]          win_wdata;
    logic                 data_ok;
    logic                 timeout;
    logic                 complete;
    logic                 load;

    assign addr_arr  = req_addr;
    assign wdata_arr = req_wdata;

    // Round-robin pick: first request above the last winner, else wrap to the lowest.
    always_comb begin
        req_m      = req & ~grant_q;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        win_write  = 1'b0;
        win_addr   = '0;
        win_wdata  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_m[i] && (PTR_W'(i) > last_q)) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_m[i]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_found && (PTR_W'(i) == win_idx)) begin
                win_onehot[i] = 1'b1;
                win_write     = req_write[i];
                win_addr      = addr_arr[i];
                win_wdata     = wdata_arr[i];
            end
        end
    end

    // Completion strobe and response, combinational in the finishing data-phase cycle.
    always_comb begin
        data_ok  = (state_q == S_DATA) && m_ready;
        timeout  = TO_EN && (state_q == S_DATA) && !m_ready && (wait_q == CNT_W'(TIMEOUT_CYCLES));
        complete = data_ok || timeout;
        done     = complete ? grant_q : '0;
        rdata    = data_ok ? m_rdata : 32'h0;
        resp     = timeout || (data_ok && m_resp);
    end

    // Next-state and next-output logic for the address/data phase sequencer.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        wait_d    = wait_q;
        m_trans_d = m_trans_q;
        m_write_d = m_write_q;
        m_addr_d  = m_addr_q;
        wdata_d   = wdata_q;
        m_wdata_d = m_wdata_q;
        load      = 1'b0;

        case (state_q)
            S_IDLE: begin
                m_trans_d = HTRANS_IDLE;
                wait_d    = '0;
                load      = win_found;
            end
            S_ADDR: begin
                if (m_ready) begin
                    state_d   = S_DATA;
                    m_trans_d = HTRANS_IDLE;
                    m_wdata_d = wdata_q;
                    wait_d    = '0;
                end
            end
            S_DATA: begin
                if (complete) begin
                    wait_d = '0;
                    if (win_found) begin
                        load = 1'b1;
                    end else begin
                        state_d   = S_IDLE;
                        grant_d   = '0;
                        m_trans_d = HTRANS_IDLE;
                    end
                end else if (!m_ready && (wait_q != '1)) begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                grant_d   = '0;
                m_trans_d = HTRANS_IDLE;
            end
        endcase

        if (load) begin
            state_d   = S_ADDR;
            grant_d   = win_onehot;
            last_d    = win_idx;
            m_trans_d = HTRANS_NONSEQ;
            m_write_d = win_write;
            m_addr_d  = win_addr;
            wdata_d   = win_wdata;
        end
    end

    // State and registered master-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= PTR_W'(NUM_REQ - 1);
            wait_q    <= '0;
            m_trans_q <= HTRANS_IDLE;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            wdata_q   <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wait_q    <= wait_d;
            m_trans_q <= m_trans_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            wdata_q   <= wdata_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign grant   = grant_q;
    assign m_trans = m_trans_q;
    assign m_write = m_write_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule
